// File: rtl/regfile_pkg.sv
// Shared defaults for the multi-port register file and its busy scoreboard.
package regfile_pkg;

  localparam int DefaultDataWidth = 32;
  localparam int DefaultAddrWidth = 5;
  localparam int DefaultNumRead   = 2;
  localparam int ZeroRegIdx       = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for outstanding multicycle loads; mark beats clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DefaultAddrWidth,
  parameter int NUM_READ   = DefaultNumRead
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic                            MarkEn,
  input  logic [ADDR_WIDTH-1:0]           MarkAddr,
  input  logic                            ClearEn,
  input  logic [ADDR_WIDTH-1:0]           ClearAddr,
  input  logic                            ForwardEn,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  ReadAddr,
  output logic [NUM_READ-1:0]             ReadBusy
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic [NUM_REGS-1:0] busy;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      busy <= '0;
    end else begin
      if (ClearEn) busy[ClearAddr] <= 1'b0;
      if (MarkEn)  busy[MarkAddr]  <= 1'b1;
    end
  end

  // A load landing this cycle already satisfies the reader when forwarding is on.
  for (genvar k = 0; k < NUM_READ; k++) begin : gBusy
    logic [ADDR_WIDTH-1:0] addr;
    assign addr        = ReadAddr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign ReadBusy[k] = busy[addr] && !(ForwardEn && (ClearAddr == addr));
  end

endmodule

// File: rtl/general_regfile_mp.sv
// Multi-read, dual-write register file with optional zero register,
// write-to-read forwarding and a load scoreboard.
module general_regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DefaultDataWidth,
  parameter int ADDR_WIDTH = DefaultAddrWidth,
  parameter int NUM_READ   = DefaultNumRead,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  ReadAddr,
  output logic [NUM_READ*DATA_WIDTH-1:0]  ReadData,
  output logic [NUM_READ-1:0]             ReadBusy,
  input  logic                            WriteEnA,
  input  logic [ADDR_WIDTH-1:0]           WriteAddrA,
  input  logic [DATA_WIDTH-1:0]           WriteDataA,
  input  logic                            WriteEnB,
  input  logic [ADDR_WIDTH-1:0]           WriteAddrB,
  input  logic [DATA_WIDTH-1:0]           WriteDataB,
  input  logic                            MarkEn,
  input  logic [ADDR_WIDTH-1:0]           MarkAddr
);

  localparam int                    NUM_REGS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZeroAddr = ADDR_WIDTH'(ZeroRegIdx);
  localparam logic                  ZeroOn   = (ZERO_REG != 0);
  localparam logic                  BypassOn = (BYPASS != 0);

  function automatic logic isZero(input logic [ADDR_WIDTH-1:0] addr);
    return ZeroOn && (addr == ZeroAddr);
  endfunction

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  writeA;
  logic                  writeB;
  logic                  markQual;

  assign writeA   = WriteEnA && !isZero(WriteAddrA);
  assign writeB   = WriteEnB && !isZero(WriteAddrB);
  assign markQual = MarkEn   && !isZero(MarkAddr);

  // Port A is applied last so it wins a same-address collision.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (writeB) regs[WriteAddrB] <= WriteDataB;
      if (writeA) regs[WriteAddrA] <= WriteDataA;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : gRead
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;

    assign addr = ReadAddr[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      data = regs[addr];
      if (BypassOn && WriteEnB && (WriteAddrB == addr)) data = WriteDataB;
      if (BypassOn && WriteEnA && (WriteAddrA == addr)) data = WriteDataA;
      if (isZero(addr)) data = '0;
    end

    assign ReadData[k*DATA_WIDTH +: DATA_WIDTH] = data;
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ)
  ) uScoreboard (
    .Clock     (Clock),
    .Reset     (Reset),
    .MarkEn    (markQual),
    .MarkAddr  (MarkAddr),
    .ClearEn   (WriteEnB),
    .ClearAddr (WriteAddrB),
    .ForwardEn (BypassOn && WriteEnB),
    .ReadAddr  (ReadAddr),
    .ReadBusy  (ReadBusy)
  );

endmodule
